conv_eng_pipe: RTL



---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_add_tree.sv | 102 ++++++++++
 rtl/conv_eng_pipe.sv | 123 ++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants and width helpers for the convolution datapath (line buffer and engine).
package conv_pkg;

  localparam int CONV_DATA_W = 8;
  localparam int CONV_KERNEL = 9;
  localparam int CONV_OUT_W  = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int prod_w(input int data_w);
    return 2 * data_w;
  endfunction

  // Tree output width: one extra bit per reduction level, so no add can overflow.
  function automatic int sum_w(input int data_w, input int kernel);
    return prod_w(data_w) + clog2(kernel);
  endfunction

endpackage

// File: rtl/conv_add_tree.sv
// Registered adder tree: one pipeline level per reduction step, with valid/first/last
// sideband travelling alongside. All levels advance together on en.
module conv_add_tree
  import conv_pkg::*;
#(
  parameter int N    = 9,
  parameter int IN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     in_vld,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [N*IN_W-1:0]        in_data,
  output logic                     out_vld,
  output logic                     out_first,
  output logic                     out_last,
  output logic [IN_W+clog2(N)-1:0] out_sum
);

  localparam int LEVELS = clog2(N);
  localparam int OW     = IN_W + LEVELS;

  function automatic int cnt(input int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  function automatic int off(input int l);
    int s;
    s = 0;
    for (int k = 0; k < l; k++) s += cnt(k);
    return s;
  endfunction

  localparam int TOTAL     = off(LEVELS + 1);
  localparam int REG_NODES = TOTAL - N;

  logic [N*OW-1:0]         lvl0;
  logic [TOTAL*OW-1:0]     nodes;
  logic [REG_NODES*OW-1:0] tree_q, tree_d;
  logic [LEVELS-1:0]       vld_q, vld_d;
  logic [LEVELS-1:0]       first_q, first_d;
  logic [LEVELS-1:0]       last_q, last_d;

  always_comb begin
    lvl0 = '0;
    for (int i = 0; i < N; i++)
      lvl0[i*OW +: OW] = OW'(in_data[i*IN_W +: IN_W]);
  end

  // All levels share one flat node vector: level 0 at the bottom, root at the top.
  assign nodes = {tree_q, lvl0};

  always_comb begin
    tree_d = '0;
    for (int l = 1; l <= LEVELS; l++) begin
      for (int j = 0; j < cnt(l); j++) begin
        tree_d[(off(l) - N + j)*OW +: OW] =
          nodes[(off(l-1) + 2*j)*OW +: OW] +
          ((2*j + 1 < cnt(l-1)) ? nodes[(off(l-1) + 2*j + 1)*OW +: OW] : '0);
      end
    end
  end

  always_comb begin
    vld_d      = vld_q;
    first_d    = first_q;
    last_d     = last_q;
    vld_d[0]   = in_vld;
    first_d[0] = in_first;
    last_d[0]  = in_last;
    for (int l = 1; l < LEVELS; l++) begin
      vld_d[l]   = vld_q[l-1];
      first_d[l] = first_q[l-1];
      last_d[l]  = last_q[l-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_q  <= '0;
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (clr) begin
      vld_q <= '0;
    end else if (en) begin
      tree_q  <= tree_d;
      vld_q   <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign out_vld   = vld_q[LEVELS-1];
  assign out_first = first_q[LEVELS-1];
  assign out_last  = last_q[LEVELS-1];
  assign out_sum   = nodes[off(LEVELS)*OW +: OW];

endmodule

// File: rtl/conv_eng_pipe.sv
// Pipelined convolution engine: multiply stage, registered adder tree, channel accumulator.
// Define CONV_SAT_EN to clip results to OUT_W bits and flag it on ovf; otherwise truncate.
module conv_eng_pipe
  import conv_pkg::*;
#(
  parameter int DATA_W = CONV_DATA_W,
  parameter int KERNEL = CONV_KERNEL,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = CONV_OUT_W
) (
  input  logic                     clk,
  input  logic                     rstn_,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [KERNEL*DATA_W-1:0] nums_to_multiply,
  input  logic [KERNEL*DATA_W-1:0] weights,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         result,
  output logic                     ovf
);

  localparam int PROD_W = prod_w(DATA_W);
  localparam int SUM_W  = sum_w(DATA_W, KERNEL);

  logic                     adv;
  logic [KERNEL*PROD_W-1:0] prod_d, prod_q;
  logic                     m_vld_q, m_first_q, m_last_q;
  logic                     t_vld, t_first, t_last;
  logic [SUM_W-1:0]         t_sum;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [OUT_W-1:0]         result_q, result_d;
  logic                     out_valid_q, ovf_q, ovf_d;

  // Global stall: every stage holds while a result waits for the writer.
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  always_comb begin
    prod_d = '0;
    for (int i = 0; i < KERNEL; i++)
      prod_d[i*PROD_W +: PROD_W] = PROD_W'(nums_to_multiply[i*DATA_W +: DATA_W]) *
                                   PROD_W'(weights[i*DATA_W +: DATA_W]);
  end

  always_ff @(posedge clk or negedge rstn_) begin
    if (!rstn_) begin
      m_vld_q   <= 1'b0;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
      prod_q    <= '0;
    end else if (clr) begin
      m_vld_q <= 1'b0;
    end else if (adv) begin
      m_vld_q   <= in_valid;
      m_first_q <= in_first;
      m_last_q  <= in_last;
      prod_q    <= prod_d;
    end
  end

  conv_add_tree #(
    .N    (KERNEL),
    .IN_W (PROD_W)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rstn_),
    .en        (adv),
    .clr       (clr),
    .in_vld    (m_vld_q),
    .in_first  (m_first_q),
    .in_last   (m_last_q),
    .in_data   (prod_q),
    .out_vld   (t_vld),
    .out_first (t_first),
    .out_last  (t_last),
    .out_sum   (t_sum)
  );

  assign acc_d = t_first ? ACC_W'(t_sum) : acc_q + ACC_W'(t_sum);

`ifdef CONV_SAT_EN
  always_comb begin
    ovf_d    = (acc_d >> OUT_W) != '0;
    result_d = ovf_d ? '1 : acc_d[OUT_W-1:0];
  end
`else
  assign ovf_d    = 1'b0;
  assign result_d = acc_d[OUT_W-1:0];
`endif

  always_ff @(posedge clk or negedge rstn_) begin
    if (!rstn_) begin
      acc_q       <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      acc_q       <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= 1'b0;
      if (t_vld) begin
        acc_q <= acc_d;
        if (t_last) begin
          result_q    <= result_d;
          ovf_q       <= ovf_d;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule
